patch_fetch_sequencer: RTL

Upstream feeder for the patching datapath. On a start command it walks the M activation lanes of a group and issues one cache read per lane flagged in a patch mask. Each returned activation is written into the patching unit's activation_cache through an index/store_enable/data write port. It also builds the per-lane patch bit vector p and reports lanes whose fetch failed.

---
 rtl/patch_fetch_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/patch_fetch_sequencer.sv
// patch_fetch_sequencer
// Upstream feeder for the patching datapath. On an accepted start it walks
// the M lanes of a group, issues one cache read for every lane flagged in
// the latched patch mask, writes each returned activation into the
// activation cache, and builds the per-lane patch bit vector.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   start             command strobe, accepted only while idle
//   base_addr         cache address of lane 0 (latched on start)
//   patch_mask        lanes needing a fetch (latched on start)
//   busy, done        group in progress / one-cycle end-of-group pulse
//   cache_request     one-cycle read request, with cache_address
//   cache_read_write  constant 1 (read)
//   cache_data/valid/error  read response (sampled only while waiting)
//   store_enable      one-cycle write strobe with index and store_data
//   p_out             lane i holds a valid cached value
//   err_count         failed fetches in the current/last group
//   timeout_seen      at least one lane timed out in the current/last group
module patch_fetch_sequencer #(
  parameter int N          = 16,
  parameter int M          = 16,
  parameter int ADDR_WIDTH = 21,
  parameter int TIMEOUT    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [M-1:0]          patch_mask,
  output logic                  busy,
  output logic                  done,
  output logic                  cache_request,
  output logic                  cache_read_write,
  output logic [ADDR_WIDTH-1:0] cache_address,
  input  logic [N-1:0]          cache_data,
  input  logic                  cache_valid,
  input  logic                  cache_error,
  output logic                  store_enable,
  output logic [$clog2(M)-1:0]  index,
  output logic [N-1:0]          store_data,
  output logic [M-1:0]          p_out,
  output logic [$clog2(M):0]    err_count,
  output logic                  timeout_seen
);

  localparam int LW = $clog2(M);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0] LAST_LANE  = LW'(M - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, SCAN, ISSUE, WAIT, STORE, DONE
  } state_t;

  state_t                  state, next_state;
  logic [LW-1:0]           lane;
  logic [TW-1:0]           timer;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [M-1:0]            mask_q;
  logic                    lane_last;
  logic                    lane_inc;
  logic                    fetch_fail;
  logic                    fetch_timeout;

  assign cache_read_write = 1'b1;
  assign lane_last        = (lane == LAST_LANE);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    next_state    = state;
    lane_inc      = 1'b0;
    fetch_fail    = 1'b0;
    fetch_timeout = 1'b0;
    case (state)
      IDLE:  if (start) next_state = SCAN;
      SCAN: begin
        if (mask_q[lane])   next_state = ISSUE;
        else if (lane_last) next_state = DONE;
        else                lane_inc   = 1'b1;
      end
      ISSUE: next_state = WAIT;
      WAIT: begin
        // An error wins over a simultaneous valid; the timer only matters
        // when neither response arrived this cycle.
        if (cache_error) begin
          fetch_fail = 1'b1;
        end else if (cache_valid) begin
          next_state = STORE;
        end else if (timer == TIMER_LAST) begin
          fetch_fail    = 1'b1;
          fetch_timeout = 1'b1;
        end
        if (fetch_fail) begin
          next_state = lane_last ? DONE : SCAN;
          lane_inc   = !lane_last;
        end
      end
      STORE: begin
        next_state = lane_last ? DONE : SCAN;
        lane_inc   = !lane_last;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Outputs are registered from the next state, so each strobe is high for
  // exactly the cycle the FSM spends in the matching state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane          <= '0;
      timer         <= '0;
      base_q        <= '0;
      mask_q        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cache_request <= 1'b0;
      cache_address <= '0;
      store_enable  <= 1'b0;
      index         <= '0;
      store_data    <= '0;
      p_out         <= '0;
      err_count     <= '0;
      timeout_seen  <= 1'b0;
    end else begin
      busy          <= (next_state != IDLE);
      done          <= (next_state == DONE);
      cache_request <= (next_state == ISSUE);
      store_enable  <= (next_state == STORE);

      if (state == IDLE && start) begin
        base_q       <= base_addr;
        mask_q       <= patch_mask;
        p_out        <= '0;
        err_count    <= '0;
        timeout_seen <= 1'b0;
        lane         <= '0;
      end

      if (lane_inc) lane <= lane + LW'(1);

      // Address arithmetic wraps at ADDR_WIDTH bits; the carry is dropped.
      if (state == SCAN && next_state == ISSUE)
        cache_address <= base_q + ADDR_WIDTH'(lane);

      if (state == ISSUE)     timer <= '0;
      else if (state == WAIT) timer <= timer + TW'(1);

      // p_out[lane] rises together with store_enable, not a cycle later.
      if (state == WAIT && next_state == STORE) begin
        store_data  <= cache_data;
        index       <= lane;
        p_out[lane] <= 1'b1;
      end

      if (fetch_fail)    err_count    <= err_count + (LW+1)'(1);
      if (fetch_timeout) timeout_seen <= 1'b1;
    end
  end

endmodule
